// File: rtl/branch_predictor_if.sv
`default_nettype none
// ==========================================================================
// branch_predictor_if : fetch lookup, resolution update and flush bundle
// Revision: 1.0
// ==========================================================================
interface branch_predictor_if;
  logic        flush;
  logic        fetchValid;
  logic [31:0] fetchPc;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        predHit;
  logic        updateValid;
  logic        updateIsBranch;
  logic [31:0] updatePc;
  logic        updateTaken;
  logic [31:0] updateTarget;

  // Master is the pipeline side (PC generator + execute resolver).
  modport master (
    output flush, fetchValid, fetchPc,
    output updateValid, updateIsBranch, updatePc, updateTaken, updateTarget,
    input  predTaken, predTarget, predHit
  );

  modport slave (
    input  flush, fetchValid, fetchPc,
    input  updateValid, updateIsBranch, updatePc, updateTaken, updateTarget,
    output predTaken, predTarget, predHit
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ==========================================================================
// branch_predictor : direct-mapped BTB with 2-bit saturating direction counters
// Revision: 1.0
// ==========================================================================
module branch_predictor #(
  parameter int ENTRY_NUM = 16,
  parameter int INDEX_W   = $clog2(ENTRY_NUM)
) (
  input  logic              clk,
  input  logic              rstN,
  branch_predictor_if.slave bp
);
  localparam int TAG_W = 32 - INDEX_W - 2;

  logic             valid_q  [ENTRY_NUM];
  logic [TAG_W-1:0] tag_q    [ENTRY_NUM];
  logic [31:0]      target_q [ENTRY_NUM];
  logic [1:0]       ctr_q    [ENTRY_NUM];

  logic [INDEX_W-1:0] fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               fetch_hit;
  logic               upd_hit;
  logic               upd_fire;
  logic [1:0]         ctr_next;
  logic               unused_pc_bits;

  assign fetch_idx = bp.fetchPc[INDEX_W+1:2];
  assign fetch_tag = bp.fetchPc[31:INDEX_W+2];
  assign upd_idx   = bp.updatePc[INDEX_W+1:2];
  assign upd_tag   = bp.updatePc[31:INDEX_W+2];

  // Word-aligned PCs: the low update bits carry no information.
  assign unused_pc_bits = ^bp.updatePc[1:0];

  assign fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign bp.predHit    = bp.fetchValid && fetch_hit;
  assign bp.predTaken  = bp.predHit && ctr_q[fetch_idx][1];
  assign bp.predTarget = bp.predTaken ? target_q[fetch_idx] : (bp.fetchPc + 32'd4);

  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_fire = bp.updateValid && bp.updateIsBranch;

  always_comb begin
    ctr_next = ctr_q[upd_idx];
    if (bp.updateTaken) begin
      if (ctr_q[upd_idx] != 2'b11) ctr_next = ctr_q[upd_idx] + 2'b01;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) ctr_next = ctr_q[upd_idx] - 2'b01;
    end
  end

  // Flush outranks a same-cycle update; a not-taken miss never allocates.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bp.flush) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_fire) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next;
        if (bp.updateTaken) target_q[upd_idx] <= bp.updateTarget;
      end else if (bp.updateTaken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bp.updateTarget;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ==========================================================================
// tb_branch_predictor : directed + randomized checks against a table model
// Revision: 1.0
// ==========================================================================
module tb_branch_predictor;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor_if bp ();

  branch_predictor #(.ENTRY_NUM(N)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bp   (bp)
  );

  // Reference model: one record per table slot.
  bit          m_valid  [N];
  logic [31:0] m_tag    [N];
  logic [31:0] m_target [N];
  int          m_ctr    [N];

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(N));
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc / 32'(4 * N);
  endfunction

  function automatic logic [33:0] mk(logic h, logic t, logic [31:0] tgt);
    return {h, t, tgt};
  endfunction

  function automatic logic [33:0] predict(logic fv, logic [31:0] pc);
    int   i;
    logic h;
    logic t;
    i = idx_of(pc);
    h = fv && m_valid[i] && (m_tag[i] == tag_of(pc));
    t = h && (m_ctr[i] >= 2);
    return {h, t, (t ? m_target[i] : pc + 32'd4)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = '0; m_target[k] = '0; m_ctr[k] = 1;
    end
  endtask

  task automatic model_update();
    int  i;
    bit  hit;
    if (bp.flush) begin
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
      return;
    end
    if (!(bp.updateValid && bp.updateIsBranch)) return;
    i   = idx_of(bp.updatePc);
    hit = m_valid[i] && (m_tag[i] == tag_of(bp.updatePc));
    if (hit) begin
      if (bp.updateTaken) begin
        m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_target[i] = bp.updateTarget;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (bp.updateTaken) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(bp.updatePc);
      m_target[i] = bp.updateTarget;
      m_ctr[i]    = 2;
    end
  endtask

  task automatic drive_idle();
    bp.flush = 1'b0; bp.fetchValid = 1'b0; bp.fetchPc = '0;
    bp.updateValid = 1'b0; bp.updateIsBranch = 1'b0; bp.updatePc = '0;
    bp.updateTaken = 1'b0; bp.updateTarget = '0;
  endtask

  task automatic set_update(logic [31:0] pc, logic taken, logic [31:0] tgt);
    bp.updateValid = 1'b1; bp.updateIsBranch = 1'b1;
    bp.updatePc = pc; bp.updateTaken = taken; bp.updateTarget = tgt;
  endtask

  task automatic set_fetch(logic fv, logic [31:0] pc);
    bp.fetchValid = fv; bp.fetchPc = pc;
    #1;
  endtask

  // Advance one edge; the model absorbs whatever the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (rstN) model_update();
    #1;
    bp.updateValid = 1'b0; bp.flush = 1'b0;
  endtask

  function automatic logic [33:0] obs();
    return {bp.predHit, bp.predTaken, bp.predTarget};
  endfunction

  task automatic test_reset();
    logic [33:0] got;
    drive_idle();
    model_reset();
    rstN = 1'b0;
    set_fetch(1'b1, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h104)) begin
      n_fail++; $display("FAIL in_reset: got %b/%b/%h want 0/0/00000104", got[33], got[32], got[31:0]);
    end
    @(negedge clk) rstN = 1'b1;
    tick();
    set_fetch(1'b1, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h104)) begin
      n_fail++; $display("FAIL cold_lookup: got %b/%b/%h want 0/0/00000104", got[33], got[32], got[31:0]);
    end
    set_fetch(1'b0, 32'h3C);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h40)) begin
      n_fail++; $display("FAIL fetch_invalid: got %b/%b/%h want 0/0/00000040", got[33], got[32], got[31:0]);
    end
  endtask

  task automatic test_allocate();
    logic [33:0] got;
    set_update(32'h100, 1'b1, 32'h200);
    tick();
    set_fetch(1'b1, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(1, 1, 32'h200)) begin
      n_fail++; $display("FAIL allocate: got %b/%b/%h want 1/1/00000200", got[33], got[32], got[31:0]);
    end
    set_update(32'h180, 1'b1, 32'h300);
    bp.updateIsBranch = 1'b0;
    tick();
    set_fetch(1'b1, 32'h180);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h184)) begin
      n_fail++; $display("FAIL non_branch: got %b/%b/%h want 0/0/00000184", got[33], got[32], got[31:0]);
    end
  endtask

  task automatic test_hysteresis();
    // Counter walk from 10: 01,00,01,10,11,11(sat),10,01
    logic [7:0] dir  = 8'b0011_1100;
    logic [7:0] pred = 8'b0001_1110;
    logic [33:0] got;
    logic [33:0] want;
    for (int s = 7; s >= 0; s--) begin
      set_update(32'h100, dir[s], 32'h200);
      tick();
      set_fetch(1'b1, 32'h100);
      got  = obs();
      want = mk(1, pred[s], pred[s] ? 32'h200 : 32'h104);
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL hysteresis step %0d: got %b/%b/%h want %b/%b/%h",
                           7 - s, got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
      end
    end
  endtask

  task automatic test_alias();
    logic [33:0] got;
    set_fetch(1'b1, 32'h140);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h144)) begin
      n_fail++; $display("FAIL alias_miss: got %b/%b/%h want 0/0/00000144", got[33], got[32], got[31:0]);
    end
    set_update(32'h140, 1'b0, 32'h80);
    tick();
    set_fetch(1'b1, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(1, 0, 32'h104)) begin
      n_fail++; $display("FAIL alias_nt_keep: got %b/%b/%h want 1/0/00000104", got[33], got[32], got[31:0]);
    end
    set_update(32'h140, 1'b1, 32'h80);
    tick();
    set_fetch(1'b1, 32'h140);
    got = obs(); n_tests++;
    if (got !== mk(1, 1, 32'h80)) begin
      n_fail++; $display("FAIL alias_replace: got %b/%b/%h want 1/1/00000080", got[33], got[32], got[31:0]);
    end
    set_fetch(1'b1, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h104)) begin
      n_fail++; $display("FAIL alias_evicted: got %b/%b/%h want 0/0/00000104", got[33], got[32], got[31:0]);
    end
  endtask

  task automatic test_same_cycle();
    logic [33:0] got;
    bp.flush = 1'b1;
    tick();
    set_fetch(1'b1, 32'h140);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h144)) begin
      n_fail++; $display("FAIL flush_clears: got %b/%b/%h want 0/0/00000144", got[33], got[32], got[31:0]);
    end
    set_update(32'h100, 1'b1, 32'h200);
    set_fetch(1'b1, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h104)) begin
      n_fail++; $display("FAIL no_bypass: got %b/%b/%h want 0/0/00000104", got[33], got[32], got[31:0]);
    end
    tick();
    got = obs(); n_tests++;
    if (got !== mk(1, 1, 32'h200)) begin
      n_fail++; $display("FAIL update_next_cycle: got %b/%b/%h want 1/1/00000200", got[33], got[32], got[31:0]);
    end
    bp.flush = 1'b1;
    set_update(32'h300, 1'b1, 32'h400);
    tick();
    set_fetch(1'b1, 32'h300);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h304)) begin
      n_fail++; $display("FAIL flush_drops_update: got %b/%b/%h want 0/0/00000304", got[33], got[32], got[31:0]);
    end
    set_fetch(1'b1, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h104)) begin
      n_fail++; $display("FAIL flush_with_update: got %b/%b/%h want 0/0/00000104", got[33], got[32], got[31:0]);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    logic [33:0] got;
    set_fetch(1'b1, 32'hFFFF_FFFC);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h0)) begin
      n_fail++; $display("FAIL pc_wrap: got %b/%b/%h want 0/0/00000000", got[33], got[32], got[31:0]);
    end
    set_update(32'h100, 1'b1, 32'h200);
    tick();
    set_fetch(1'b0, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h104)) begin
      n_fail++; $display("FAIL gated_hit: got %b/%b/%h want 0/0/00000104", got[33], got[32], got[31:0]);
    end
    set_fetch(1'b1, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(1, 1, 32'h200)) begin
      n_fail++; $display("FAIL pre_reset_hit: got %b/%b/%h want 1/1/00000200", got[33], got[32], got[31:0]);
    end
    set_update(32'h100, 1'b0, 32'h0);
    rstN = 1'b0;
    #1;
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h104)) begin
      n_fail++; $display("FAIL async_reset: got %b/%b/%h want 0/0/00000104", got[33], got[32], got[31:0]);
    end
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    rstN = 1'b1;
    bp.updateValid = 1'b0;
    tick();
    set_fetch(1'b1, 32'h100);
    got = obs(); n_tests++;
    if (got !== mk(0, 0, 32'h104)) begin
      n_fail++; $display("FAIL post_reset_miss: got %b/%b/%h want 0/0/00000104", got[33], got[32], got[31:0]);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return $urandom;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic [33:0] got;
    logic [33:0] want;
    for (int c = 0; c < 400; c++) begin
      bp.flush          = ($urandom_range(0, 39) == 0);
      bp.updateValid    = ($urandom_range(0, 3) != 0);
      bp.updateIsBranch = ($urandom_range(0, 6) != 0);
      bp.updatePc       = rand_pc();
      bp.updateTaken    = ($urandom_range(0, 9) < 6);
      bp.updateTarget   = $urandom;
      set_fetch(($urandom_range(0, 7) != 0), rand_pc());
      got  = obs();
      want = predict(bp.fetchValid, bp.fetchPc);
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL random cycle %0d pc=%h: got %b/%b/%h want %b/%b/%h", c, bp.fetchPc,
                           got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_same_cycle();
    test_wrap_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
